song_sequencer: RTL and testbench

Plays a song out of the note ROM at a fixed tempo. Owns the ROM address counter `cnt` (7 bits) and holds each address stable for a full beat. Captures the registered 5-lane ROM word on every beat and presents it downstream as a one-cycle `note_valid` strobe with a `beat` pulse for the note-highway scroller. Provides start/pause/stop control and end-of-song detection.

---
 rtl/song_pkg.sv | 10 +
 rtl/beat_divider.sv | 33 +++
 rtl/song_sequencer.sv | 119 +++++++++++
 tb/tb_song_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/song_pkg.sv
// Shared types and default sizing for the song player.
package song_pkg;
  localparam int NOTE_W   = 5;
  localparam int ADDR_W   = 7;
  localparam int SONG_LEN = 94;

  typedef logic [NOTE_W-1:0] note_t;

  typedef enum logic [1:0] {IDLE, PLAYING, PAUSED, DONE} seq_state_t;
endpackage

// File: rtl/beat_divider.sv
// Free-running beat divider: counts 0..DIV-1 while enabled, tick on the last count.
// tick is combinational from the count register; clr has priority over en.
module beat_divider #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] count_q, count_d;

  assign tick = en && (count_q == W'(DIV - 1));

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (tick) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end
endmodule

// File: rtl/song_sequencer.sv
// Steps the note ROM address once per beat and emits each captured lane bitmap
// as a one-cycle note_valid/beat strobe; start/pause/stop control with end-of-song detect.
module song_sequencer #(
  parameter int BEAT_DIV = 2_500_000,
  parameter int SONG_LEN = song_pkg::SONG_LEN,
  parameter int ADDR_W   = song_pkg::ADDR_W,
  parameter int NOTE_W   = song_pkg::NOTE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  input  logic              stop,
  input  logic [NOTE_W-1:0] rom_data,
  output logic [ADDR_W-1:0] cnt,
  output logic [NOTE_W-1:0] note,
  output logic              note_valid,
  output logic              beat,
  output logic              playing,
  output logic              done
);
  import song_pkg::*;

  // A one-cycle beat period would sample rom_data before the ROM has caught up with cnt.
  if (BEAT_DIV < 2) begin : g_bad_div
    $error("song_sequencer: BEAT_DIV must be at least 2");
  end
  if (SONG_LEN > (2 ** ADDR_W)) begin : g_bad_len
    $error("song_sequencer: SONG_LEN does not fit in ADDR_W");
  end

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic              note_valid_q, note_valid_d;
  logic              beat_q, beat_d;
  logic              playing_q, playing_d;
  logic              done_q, done_d;
  logic              tick;
  logic              div_clr;

  assign div_clr = stop || (state_q == IDLE) || (state_q == DONE);

  beat_divider #(.DIV(BEAT_DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q == PLAYING),
    .clr  (div_clr),
    .tick (tick)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    note_d       = note_q;
    note_valid_d = 1'b0;
    beat_d       = 1'b0;
    if (stop) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) state_d = PLAYING;
        end
        PLAYING: begin
          if (tick) begin
            note_d       = rom_data;
            note_valid_d = 1'b1;
            beat_d       = 1'b1;
            if (cnt_q == ADDR_W'(SONG_LEN - 1)) begin
              state_d = DONE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
              // pause on a beat cycle lands after the note has gone out
              if (pause) state_d = PAUSED;
            end
          end else if (pause) begin
            state_d = PAUSED;
          end
        end
        PAUSED: begin
          if (pause) state_d = PLAYING;
        end
        default: state_d = IDLE;
      endcase
    end
    playing_d = (state_d == PLAYING);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      note_q       <= '0;
      note_valid_q <= 1'b0;
      beat_q       <= 1'b0;
      playing_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      note_q       <= note_d;
      note_valid_q <= note_valid_d;
      beat_q       <= beat_d;
      playing_q    <= playing_d;
      done_q       <= done_d;
    end
  end

  assign cnt        = cnt_q;
  assign note       = note_q;
  assign note_valid = note_valid_q;
  assign beat       = beat_q;
  assign playing    = playing_q;
  assign done       = done_q;
endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with BEAT_DIV=4 and a one-cycle registered ROM model.
module tb_song_sequencer;
  import song_pkg::*;

  localparam int BD = 4;
  localparam int SL = 94;

  logic       clk = 1'b0;
  logic       rst, start, pause, stop;
  note_t      rom_data;
  logic [6:0] cnt;
  note_t      note;
  logic       note_valid, beat, playing, done;

  note_t notes [SL];
  int    n_chk = 0;
  int    n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= notes[cnt];

  song_sequencer #(.BEAT_DIV(BD), .SONG_LEN(SL), .ADDR_W(7), .NOTE_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pause      (pause),
    .stop       (stop),
    .rom_data   (rom_data),
    .cnt        (cnt),
    .note       (note),
    .note_valid (note_valid),
    .beat       (beat),
    .playing    (playing),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0;
    #3;
    rst = 1'b0;
    step();
  endtask

  // start is sampled at the edge inside this task: that edge is T0
  task automatic go();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Runs edges T0+1..T0+ncyc; pause pulses at p0/p1, stop at sk, start at gk.
  // Expected beats at edges b0,b1,b2 carrying notes n0,n1,n2.
  task automatic run(input string tag, input int ncyc, input int p0, input int p1,
                     input int sk, input int gk, input int b0, input int b1, input int b2,
                     input int n0, input int n1, input int n2);
    int  idx;
    int  exp_note [3];
    logic exp_v;
    exp_note[0] = n0; exp_note[1] = n1; exp_note[2] = n2;
    idx = 0;
    for (int k = 1; k <= ncyc; k++) begin
      pause = (k == p0) || (k == p1);
      stop  = (k == sk);
      start = (k == gk);
      step();
      pause = 1'b0; stop = 1'b0; start = 1'b0;
      exp_v = (k == b0) || (k == b1) || (k == b2);
      chk($sformatf("%s_nv_k%0d", tag, k), note_valid, exp_v);
      if (exp_v && idx < 3) begin
        chk($sformatf("%s_note%0d", tag, idx), note, exp_note[idx]);
        chk($sformatf("%s_beat%0d", tag, idx), beat, 1);
        idx++;
      end
    end
  endtask

  int strobes;
  int last_k;

  initial begin
    for (int i = 0; i < SL; i++) begin
      if (i < 2)        notes[i] = 5'b00001;
      else if (i == 2)  notes[i] = 5'b00100;
      else if (i >= 91) notes[i] = 5'b00000;
      else              notes[i] = note_t'((i * 11 + 5) % 32);
    end

    // reset state and basic playback
    do_reset();
    chk("rst_cnt", cnt, 0);
    chk("rst_note", note, 0);
    chk("rst_nv", note_valid, 0);
    chk("rst_beat", beat, 0);
    chk("rst_playing", playing, 0);
    chk("rst_done", done, 0);
    go();
    chk("t1_playing", playing, 1);
    run("t1", 12, 0, 0, 0, 0, 4, 8, 12, 1, 1, 4);
    chk("t1_cnt", cnt, 3);

    // full playthrough
    do_reset();
    go();
    strobes = 0;
    last_k  = 0;
    for (int k = 1; k <= 400; k++) begin
      step();
      if (note_valid) begin
        if (strobes < SL) chk($sformatf("full_note%0d", strobes), note, notes[strobes]);
        strobes++;
        last_k = k;
      end
      if (k == 376) begin
        chk("full_done", done, 1);
        chk("full_cnt", cnt, 0);
        chk("full_playing", playing, 0);
        chk("full_last_note", note, 0);
      end
    end
    chk("full_strobes", strobes, SL);
    chk("full_last_k", last_k, 376);
    chk("full_done_hold", done, 1);

    // pause at T0+6, resume at T0+16
    do_reset();
    go();
    run("t3", 22, 6, 16, 0, 0, 4, 18, 22, 1, 1, 4);

    // pause coinciding with beat at T0+8, resume at T0+21
    do_reset();
    go();
    run("t4", 12, 8, 0, 0, 0, 4, 8, 0, 1, 1, 0);
    chk("t4_paused_playing", playing, 0);
    chk("t4_paused_note", note, 1);
    chk("t4_paused_cnt", cnt, 2);
    // continues at edge T0+13; resume at T0+21 leaves the divider at 0 -> beat at T0+25
    run("t4b", 13, 9, 0, 0, 0, 13, 0, 0, 4, 0, 0);

    // stop at T0+10, restart at T0+20
    do_reset();
    go();
    run("t5", 15, 0, 0, 10, 0, 4, 8, 0, 1, 1, 0);
    chk("t5_stop_playing", playing, 0);
    chk("t5_stop_cnt", cnt, 0);
    chk("t5_stop_note", note, 1);
    // edges T0+16..T0+26; start at T0+20 -> first beat at T0+24 with note 0
    run("t5b", 11, 0, 0, 0, 5, 9, 0, 0, 1, 0, 0);
    chk("t5_cnt", cnt, 1);

    // async reset between edges mid-song
    do_reset();
    go();
    for (int k = 1; k <= 9; k++) step();
    chk("t6_pre_cnt", cnt, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_cnt", cnt, 0);
    chk("t6_note", note, 0);
    chk("t6_nv", note_valid, 0);
    chk("t6_beat", beat, 0);
    chk("t6_playing", playing, 0);
    chk("t6_done", done, 0);
    rst = 1'b0;
    strobes = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (note_valid || playing) strobes++;
    end
    chk("t6_idle", strobes, 0);
    go();
    chk("t6_restart", playing, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
